// File: rtl/seg_data_src.sv
// rtl/seg_data_src.sv - key-controlled signed tenths counter feeding the seven-segment driver (optional debounce: SEG_DATA_SRC_DEBOUNCE_EN)
module seg_data_src #(
    parameter logic [23:0] CNT_TICK_MAX = 24'd4_999_999,
    parameter logic [19:0] CNT_DEB_MAX  = 20'd999_999,
    parameter logic [5:0]  POINT_POS    = 6'b000_010
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        key_start,
    input  logic        key_clr,
    input  logic        key_dir,
    output logic [19:0] data,
    output logic [5:0]  point,
    output logic        sign,
    output logic        seg_en
);
    localparam logic [19:0] MAG_POS_MAX = 20'd999_999;
    localparam logic [19:0] MAG_NEG_MAX = 20'd99_999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // key order in all 3-bit vectors: {dir, clr, start}
    logic [2:0] key_raw;
    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;
    logic [2:0] press;
    logic       p_start, p_clr, p_dir;

    assign key_raw = {key_dir, key_clr, key_start};

    // two-flop synchronizer input staging
    always_comb begin
        sync1_d = key_raw;
        sync2_d = sync1_q;
    end

    // synchronizer flops reset to "pressed" so a key held through reset release is never seen as a new press
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

`ifdef SEG_DATA_SRC_DEBOUNCE_EN
    // counter value on the sample that completes CNT_DEB_MAX+1 low samples, and the parked value after firing
    localparam logic [20:0] DEB_FIRE = {1'b0, CNT_DEB_MAX};
    localparam logic [20:0] DEB_DONE = DEB_FIRE + 21'd1;

    logic [2:0][20:0] deb_cnt_q, deb_cnt_d;
    logic [2:0]       press_q, press_d;

    // per-key low-time counter: clears on high, parks at DEB_DONE so one press yields one pulse
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        press_d   = '0;
        for (int k = 0; k < 3; k++) begin
            if (sync2_q[k]) begin
                deb_cnt_d[k] = '0;
            end else if (deb_cnt_q[k] != DEB_DONE) begin
                deb_cnt_d[k] = deb_cnt_q[k] + 21'd1;
            end
            press_d[k] = !sync2_q[k] && (deb_cnt_q[k] == DEB_FIRE);
        end
    end

    // counters start parked so a key held across reset must be released before it can fire
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            deb_cnt_q <= {3{DEB_DONE}};
            press_q   <= '0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            press_q   <= press_d;
        end
    end

    assign press = press_q;
`else
    logic [2:0] prev_q, prev_d;

    // previous synchronized level for falling-edge detection
    always_comb begin
        prev_d = sync2_q;
    end

    // previous level also resets to "pressed", matching the synchronizer
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign press = prev_q & ~sync2_q;
`endif

    assign p_start = press[0];
    assign p_clr   = press[1];
    assign p_dir   = press[2];

    state_t      state_q, state_d;
    logic        run, idle;
    logic [23:0] cnt_tick_q, cnt_tick_d;
    logic        tick;
    logic        dir_q, dir_d;
    logic [19:0] mag_q, mag_d;
    logic        neg_q, neg_d;
    logic [19:0] data_q, data_d;
    logic [5:0]  point_q, point_d;
    logic        sign_q, sign_d;
    logic        seg_en_q, seg_en_d;

    // FSM state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: clear beats start
    always_comb begin
        state_d = state_q;
        if (p_clr) begin
            state_d = ST_IDLE;
        end else if (p_start) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // FSM output decode
    always_comb begin
        run  = (state_q == ST_RUN);
        idle = (state_q == ST_IDLE);
    end

    assign tick = run && (cnt_tick_q == CNT_TICK_MAX);

    // tick counter: wraps in RUN, holds in PAUSE, pinned to 0 in IDLE
    always_comb begin
        cnt_tick_d = cnt_tick_q;
        if (p_clr || idle) begin
            cnt_tick_d = '0;
        end else if (run) begin
            cnt_tick_d = (cnt_tick_q == CNT_TICK_MAX) ? '0 : cnt_tick_q + 24'd1;
        end
    end

    // direction toggles on its key in every state and survives clear
    always_comb begin
        dir_d = dir_q ^ p_dir;
    end

    // sign-magnitude step; -0 is never produced and each polarity saturates at its own limit
    always_comb begin
        mag_d = mag_q;
        neg_d = neg_q;
        if (p_clr || idle) begin
            mag_d = '0;
            neg_d = 1'b0;
        end else if (tick) begin
            if (!dir_q) begin
                if (!neg_q) begin
                    if (mag_q < MAG_POS_MAX) mag_d = mag_q + 20'd1;
                end else begin
                    mag_d = mag_q - 20'd1;
                    neg_d = (mag_q != 20'd1);
                end
            end else begin
                if (neg_q) begin
                    if (mag_q < MAG_NEG_MAX) mag_d = mag_q + 20'd1;
                end else if (mag_q == 20'd0) begin
                    mag_d = 20'd1;
                    neg_d = 1'b1;
                end else begin
                    mag_d = mag_q - 20'd1;
                end
            end
        end
    end

    // registered display outputs
    always_comb begin
        data_d   = mag_q;
        sign_d   = neg_q;
        point_d  = POINT_POS;
        seg_en_d = 1'b1;
    end

    // core state and output registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_tick_q <= '0;
            dir_q      <= 1'b0;
            mag_q      <= '0;
            neg_q      <= 1'b0;
            data_q     <= '0;
            point_q    <= '0;
            sign_q     <= 1'b0;
            seg_en_q   <= 1'b0;
        end else begin
            cnt_tick_q <= cnt_tick_d;
            dir_q      <= dir_d;
            mag_q      <= mag_d;
            neg_q      <= neg_d;
            data_q     <= data_d;
            point_q    <= point_d;
            sign_q     <= sign_d;
            seg_en_q   <= seg_en_d;
        end
    end

    assign data   = data_q;
    assign point  = point_q;
    assign sign   = sign_q;
    assign seg_en = seg_en_q;

endmodule

// File: tb/tb_seg_data_src.sv
// tb/tb_seg_data_src.sv - randomized self-checking bench for seg_data_src against a signed-integer reference model
module tb_seg_data_src;
    localparam int         TICK_MAX  = 9;
    localparam int         DEB_MAX   = 4;
    localparam logic [5:0] POINT_POS = 6'b000_010;
`ifdef SEG_DATA_SRC_DEBOUNCE_EN
    localparam int PRESS_LAT = DEB_MAX + 3;
    localparam int MIN_LOW   = DEB_MAX + 1;
`else
    localparam int PRESS_LAT = 2;
    localparam int MIN_LOW   = 1;
`endif
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        key_start = 1'b1;
    logic        key_clr   = 1'b1;
    logic        key_dir   = 1'b1;
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign;
    logic        seg_en;

    int total = 0;
    int bad   = 0;

    seg_data_src #(
        .CNT_TICK_MAX(24'd9),
        .CNT_DEB_MAX (20'd4),
        .POINT_POS   (POINT_POS)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .key_start(key_start),
        .key_clr  (key_clr),
        .key_dir  (key_dir),
        .data     (data),
        .point    (point),
        .sign     (sign),
        .seg_en   (seg_en)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // reference model: value as a plain signed integer, key effects scheduled by absolute cycle
    int         cyc = 0;
    int         m_st = M_IDLE, m_ph = 0, m_v = 0, m_data = 0;
    bit         m_dir = 0, m_sign = 0, m_en = 0;
    logic [5:0] m_point = '0;
    bit         ev_start[int];
    bit         ev_clr[int];
    bit         ev_dir[int];
    bit         e_s, e_c, e_d, e_tk;
    bit         chk_en = 0;

    function automatic int step_v(input int v, input bit down);
        if (!down) return (v < 999_999) ? v + 1 : v;
        return (v > -99_999) ? v - 1 : v;
    endfunction

    always @(posedge sys_clk) begin
        cyc++;
        if (!sys_rst_n) begin
            m_st = M_IDLE; m_ph = 0; m_v = 0; m_dir = 0;
            m_data = 0; m_sign = 0; m_point = '0; m_en = 0;
        end else begin
            e_s = ev_start.exists(cyc);
            e_c = ev_clr.exists(cyc);
            e_d = ev_dir.exists(cyc);
            m_data  = (m_v < 0) ? -m_v : m_v;
            m_sign  = (m_v < 0);
            m_point = POINT_POS;
            m_en    = 1;
            e_tk = (m_st == M_RUN) && (m_ph == TICK_MAX);
            if (e_c) begin
                m_st = M_IDLE; m_ph = 0; m_v = 0;
            end else begin
                if (e_tk) m_v = step_v(m_v, m_dir);
                if (m_st == M_RUN) m_ph = (m_ph == TICK_MAX) ? 0 : m_ph + 1;
                if (e_s) m_st = (m_st == M_RUN) ? M_PAUSE : M_RUN;
            end
            if (e_d) m_dir = !m_dir;
        end
    end

    always @(negedge sys_clk) begin
        if (chk_en && sys_rst_n) begin
            chk("data",   data,   m_data);
            chk("sign",   sign,   m_sign);
            chk("point",  point,  m_point);
            chk("seg_en", seg_en, m_en);
        end
    end

    task automatic press(input bit s, input bit c, input bit d, input int low);
        int eff;
        @(negedge sys_clk);
        eff = cyc + 1 + PRESS_LAT;
        if (low >= MIN_LOW) begin
            if (s) ev_start[eff] = 1;
            if (c) ev_clr[eff]   = 1;
            if (d) ev_dir[eff]   = 1;
        end
        key_start = !s;
        key_clr   = !c;
        key_dir   = !d;
        repeat (low) @(negedge sys_clk);
        key_start = 1'b1;
        key_clr   = 1'b1;
        key_dir   = 1'b1;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic wait_data(input int v, input bit neg, input int budget);
        int n = 0;
        while (!(data == v[19:0] && sign == neg) && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        chk("reach_data", data, v);
        chk("reach_sign", sign, neg);
    endtask

    task automatic preload(input int v);
        @(negedge sys_clk);
        force dut.mag_q = (v < 0) ? 20'(-v) : 20'(v);
        force dut.neg_q = (v < 0);
        m_v = v;
        @(negedge sys_clk);
        release dut.mag_q;
        release dut.neg_q;
    endtask

    initial begin
        int r;
        // reset values
        repeat (3) @(negedge sys_clk);
        chk("rst_data",   data,   0);
        chk("rst_sign",   sign,   0);
        chk("rst_point",  point,  0);
        chk("rst_seg_en", seg_en, 0);
        sys_rst_n = 1'b1;
        chk_en = 1;
        @(negedge sys_clk);
        chk("first_point",  point,  POINT_POS);
        chk("first_seg_en", seg_en, 1);
        idle_cycles(100);
        chk("idle_data", data, 0);

        // run up to 10, pause 50 cycles, resume
        press(1, 0, 0, 8);
        wait_data(10, 0, 200);
        press(1, 0, 0, 8);
        idle_cycles(50);
        press(1, 0, 0, 8);
        idle_cycles(40);

        // zero crossing downward and back
        press(0, 1, 0, 8);
        press(1, 0, 0, 8);
        wait_data(2, 0, 200);
        press(0, 0, 1, 8);
        idle_cycles(5 * (TICK_MAX + 1));
        press(0, 0, 1, 8);
        idle_cycles(4 * (TICK_MAX + 1));

        // clear and start together while running
        press(1, 1, 0, 8);
        chk("clr_data", data, 0);
        chk("clr_sign", sign, 0);
        press(1, 0, 0, 8);
        idle_cycles(40);

        // positive limit
        press(1, 0, 0, 8);
        if (m_dir) press(0, 0, 1, 8);
        preload(999_998);
        press(1, 0, 0, 8);
        idle_cycles(40);
        chk("pos_limit", data, 999_999);

        // negative limit
        press(1, 0, 0, 8);
        press(0, 0, 1, 8);
        preload(-99_998);
        press(1, 0, 0, 8);
        idle_cycles(40);
        chk("neg_limit", data, 99_999);
        chk("neg_sign",  sign, 1);

        // short glitches on start, then a clean press
        press(0, 1, 0, 8);
        press(1, 0, 0, 3);
        idle_cycles(30);
        press(1, 0, 0, 3);
        idle_cycles(30);
        press(1, 0, 0, 6);
        idle_cycles(30);

        // asynchronous reset mid-run with start held across release
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        key_start = 1'b0;
        #1;
        chk("arst_data",   data,   0);
        chk("arst_sign",   sign,   0);
        chk("arst_point",  point,  0);
        chk("arst_seg_en", seg_en, 0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        idle_cycles(20);
        key_start = 1'b1;
        idle_cycles(10);
        chk("held_key_data", data, 0);
        press(1, 0, 0, 8);
        idle_cycles(40);

        // randomized key traffic
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 3)      press(1, 0, 0, $urandom_range(MIN_LOW, 10));
            else if (r <= 5) press(0, 0, 1, $urandom_range(MIN_LOW, 10));
            else if (r == 6) press(0, 1, 0, $urandom_range(MIN_LOW, 10));
            else if (r == 7) press(1, 0, 0, $urandom_range(1, 8));
            else             idle_cycles($urandom_range(5, 60));
        end
        idle_cycles(20);

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
